// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op_i encodings driven by the Decoder
//   - FSM state type
//   - ALUOp extension codes that route HI/LO into the write-back mux
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Decoder ALUOp codes selecting HI or LO on the MemtoReg mux (MFHI/MFLO).
  localparam logic [3:0] ALUOP_MFHI = 4'd8;
  localparam logic [3:0] ALUOP_MFLO = 4'd9;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: turns magnitude results into final HI/LO values.
//   is_div_i    : 1 = mag_i is {remainder, quotient}, 0 = mag_i is a product
//   neg_lo_i    : negate product (mult) or quotient (div)
//   neg_hi_i    : negate remainder (div only; remainder follows dividend sign)
//   div_zero_i  : divisor was zero, LO forced to all ones
//   mag_i       : 2*WIDTH magnitude result from the iterative stage
//   hi_o, lo_o  : corrected HI/LO
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic               neg_lo_i,
  input  logic               neg_hi_i,
  input  logic               div_zero_i,
  input  logic [2*WIDTH-1:0] mag_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam logic [2*WIDTH-1:0] ONE_2W = 1;
  localparam logic [WIDTH-1:0]   ONE_W  = 1;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = neg_lo_i ? (~mag_i + ONE_2W) : mag_i;
    quo  = neg_lo_i ? (~mag_i[WIDTH-1:0] + ONE_W) : mag_i[WIDTH-1:0];
    // With a zero divisor the remainder magnitude is |src1|; restoring its
    // sign reproduces src1 exactly, including the MIN case.
    rem  = neg_hi_i ? (~mag_i[2*WIDTH-1:WIDTH] + ONE_W) : mag_i[2*WIDTH-1:WIDTH];
    if (is_div_i) begin
      hi_o = rem;
      lo_o = div_zero_i ? '1 : quo;
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO registers.
//   clk_i    : clock
//   rst_i    : asynchronous active-low reset
//   start_i  : request, sampled in IDLE only
//   op_i     : MULT/MULTU/DIV/DIVU/MTHI/MTLO (6-7 ignored)
//   src1_i   : multiplicand / dividend / MTHI-MTLO data
//   src2_i   : multiplier / divisor
//   abort_i  : cancel in-flight operation (CALC or FIX)
//   busy_o   : state is not IDLE
//   done_o   : one-cycle pulse when HI/LO hold a new MULT/DIV result
//   hi_o     : HI register
//   lo_o     : LO register
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
// CALC  | WIDTH iterations of shift-add or restoring division
// FIX   | sign correction, HI/LO write, done pulse on exit
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    src1_i,
  input  logic [WIDTH-1:0]    src2_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE_W    = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div_i   (is_div_q),
    .neg_lo_i   (neg_lo_q),
    .neg_hi_i   (neg_hi_q),
    .div_zero_i (div0_q),
    .mag_i      (acc_q),
    .hi_o       (fix_hi),
    .lo_o       (fix_lo)
  );

  always_comb begin
    signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    a_neg     = signed_op && src1_i[WIDTH-1];
    b_neg     = signed_op && src2_i[WIDTH-1];
    a_mag     = a_neg ? (~src1_i + ONE_W) : src1_i;
    b_mag     = b_neg ? (~src2_i + ONE_W) : src2_i;

    // Multiply: acc = {partial, multiplier}; add multiplicand into the upper
    // half when the current multiplier bit is set, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit
    // into the remainder and try subtracting the divisor. Bit WIDTH of the
    // difference is the borrow.
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (op_i)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d  = CALC;
              cnt_d    = '0;
              is_div_d = op_i[1];
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg;
              div0_d   = (src2_i == '0);
              if (op_i[1]) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                opb_d = b_mag;
              end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag};
                opb_d = a_mag;
              end
            end
            MDU_MTHI: hi_d = src1_i;
            MDU_MTLO: lo_d = src1_i;
            default: ;
          endcase
        end
      end

      CALC: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!abort_i) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [2:0]    op_i;
  logic [W-1:0]  src1_i, src2_i;
  logic          abort_i;
  logic          busy_o, done_o;
  logic [W-1:0]  hi_o, lo_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t sb_q[$];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint          sp;
    longint unsigned up;
    int              ia, ib;
    logic [W-1:0]    q, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      MDU_MULT: begin
        sp = longint'(ia) * longint'(ib);
        return sp;
      end
      MDU_MULTU: begin
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        return up;
      end
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done hi=%h lo=%h required=no_done", hi_o, lo_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_hilo"}, {hi_o, lo_o}, {e.hi, e.lo});
      end
    end
  end

  // Called at a negedge: drives a request, pushes its expectation, and
  // returns just after the accepting rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_done, input logic [63:0] exp_hilo, input string name);
    exp_t e;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    if (expect_done) begin
      e.hi   = exp_hilo[63:32];
      e.lo   = exp_hilo[31:0];
      e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Counts cycles after acceptance until done; returns at the done negedge.
  task automatic wait_done(input string name);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen     = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        chk({name, "_latency"}, 64'(i), 64'(LAT));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        chk({name, "_busy_at_done"}, 64'(busy_o), 64'd0);
        seen = 1;
        break;
      end
      if (busy_o) busy_cnt++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_100", name);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp_hilo, input string name);
    @(negedge clk);
    issue(op, a, b, 1'b1, exp_hilo, name);
    wait_done(name);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] hi_s, lo_s;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    op_i    = '0;
    src1_i  = '0;
    src2_i  = '0;
    #3;
    chk("reset_hilo", {hi_o, lo_o}, 64'h0);
    chk("reset_busy_done", {62'h0, busy_o, done_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed results.
    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB}, "mult_neg3x7");
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7by2");
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},         "div_overflow");
    run_op(MDU_DIVU,  32'd100,       32'd0,         {32'h0000_0064, 32'hFFFF_FFFF}, "divu_by0");
    run_op(MDU_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "div_neg5by0");

    // Start during busy is ignored; abort in CALC discards the result.
    hi_s = hi_o;
    lo_s = lo_o;
    @(negedge clk);
    issue(MDU_MULT, 32'd2, 32'd3, 1'b0, 64'h0, "mult_aborted");
    repeat (4) @(negedge clk);
    issue(MDU_DIVU, 32'd9, 32'd3, 1'b0, 64'h0, "divu_ignored");
    chk("busy_after_ignored_start", 64'(busy_o), 64'd1);
    repeat (4) @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    chk("busy_after_abort", 64'(busy_o), 64'd0);
    repeat (40) @(negedge clk);
    chk("hilo_after_abort", {hi_o, lo_o}, {hi_s, lo_s});
    chk("busy_idle_after_abort", 64'(busy_o), 64'd0);

    // MTHI / MTLO write at the same edge and never go busy.
    @(negedge clk);
    issue(MDU_MTHI, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 64'h0, "mthi");
    chk("mthi_hilo", {hi_o, lo_o}, {32'h0000_1234, lo_s});
    chk("mthi_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    issue(MDU_MTLO, 32'hCAFE_0001, 32'h0, 1'b0, 64'h0, "mtlo");
    chk("mtlo_hilo", {hi_o, lo_o}, {32'h0000_1234, 32'hCAFE_0001});

    // Reserved op is ignored.
    @(negedge clk);
    issue(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0, 64'h0, "reserved");
    chk("reserved_busy", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    chk("reserved_hilo", {hi_o, lo_o}, {32'h0000_1234, 32'hCAFE_0001});

    // Abort in the FIX cycle: no write, no done.
    @(negedge clk);
    issue(MDU_MULTU, 32'd1000, 32'd1000, 1'b0, 64'h0, "multu_fix_abort");
    repeat (W + 1) @(negedge clk);
    chk("busy_in_fix", 64'(busy_o), 64'd1);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("hilo_after_fix_abort", {hi_o, lo_o}, {32'h0000_1234, 32'hCAFE_0001});

    // Start and abort together in IDLE: start wins.
    @(negedge clk);
    abort_i = 1'b1;
    issue(MDU_MULTU, 32'd6, 32'd7, 1'b1, {32'h0, 32'd42}, "start_with_abort");
    abort_i = 1'b0;
    wait_done("start_with_abort");

    // Back-to-back: new start in the done cycle is accepted.
    issue(MDU_MULTU, 32'd5, 32'd5, 1'b1, {32'h0, 32'd25}, "b2b_multu");
    wait_done("b2b_multu");

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", n, rop));
    end

    // Asynchronous reset mid-divide clears everything immediately.
    @(negedge clk);
    issue(MDU_DIV, 32'd12345, 32'd7, 1'b0, 64'h0, "div_reset");
    repeat (11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("hilo_after_reset_idle", {hi_o, lo_o}, 64'h0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
